// File: rtl/stepper_move_ctrl_if.sv
// Move-command channel: valid/ready handshake carrying step count and direction,
// plus the asynchronous-to-the-handshake abort request.
interface stepper_move_ctrl_if #(
  parameter int STEPS_W = 16
);
  logic               cmd_valid;
  logic               cmd_ready;
  logic [STEPS_W-1:0] cmd_steps;
  logic               cmd_dir;
  logic               abort;

  modport master (output cmd_valid, cmd_steps, cmd_dir, abort, input cmd_ready);
  modport slave  (input cmd_valid, cmd_steps, cmd_dir, abort, output cmd_ready);
endinterface

// File: rtl/stepper_move_ctrl.sv
// Trapezoidal step sequencer: accepts a move, emits step pulses on a linear
// accel/cruise/decel period ramp and tracks the signed absolute position.
module stepper_move_ctrl #(
  parameter int START_DIV = 250000,
  parameter int MIN_DIV   = 125000,
  parameter int ACCEL_DEC = 2500,
  parameter int DIV_W     = 20,
  parameter int STEPS_W   = 16,
  parameter int POS_W     = 32
) (
  input  logic                      CLK,
  input  logic                      RST,
  stepper_move_ctrl_if.slave        cmd,
  output logic                      step_pulse,
  output logic                      dir,
  output logic                      busy,
  output logic                      done,
  output logic [STEPS_W-1:0]        steps_left,
  output logic signed [POS_W-1:0]   position
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACCEL,
    S_CRUISE,
    S_DECEL,
    S_DONE
  } state_t;

  localparam logic [DIV_W-1:0] START_V = DIV_W'(START_DIV);
  localparam logic [DIV_W-1:0] MIN_V   = DIV_W'(MIN_DIV);
  localparam logic [DIV_W-1:0] DEC_V   = DIV_W'(ACCEL_DEC);
  localparam logic [DIV_W:0]   START_X = {1'b0, START_V};
  localparam logic [DIV_W:0]   MIN_X   = {1'b0, MIN_V};
  localparam logic [DIV_W:0]   DEC_X   = {1'b0, DEC_V};

  state_t             state_q, state_d;
  logic [DIV_W-1:0]   cnt_q, cnt_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [STEPS_W-1:0] ramp_q, ramp_d;
  logic [STEPS_W-1:0] steps_left_q, steps_left_d;
  logic               dir_q, dir_d;
  logic [POS_W-1:0]   pos_q, pos_d;
  logic               step_pulse_q, step_pulse_d;
  logic               done_q, done_d;
  logic               cmd_ready_q, cmd_ready_d;
  logic               busy_q, busy_d;

  logic [STEPS_W-1:0] rem;
  logic [DIV_W:0]     div_x;
  logic [DIV_W:0]     div_up;
  logic               run;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      div_q        <= '0;
      ramp_q       <= '0;
      steps_left_q <= '0;
      dir_q        <= 1'b0;
      pos_q        <= '0;
      step_pulse_q <= 1'b0;
      done_q       <= 1'b0;
      cmd_ready_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      div_q        <= div_d;
      ramp_q       <= ramp_d;
      steps_left_q <= steps_left_d;
      dir_q        <= dir_d;
      pos_q        <= pos_d;
      step_pulse_q <= step_pulse_d;
      done_q       <= done_d;
      cmd_ready_q  <= cmd_ready_d;
      busy_q       <= busy_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    div_d        = div_q;
    ramp_d       = ramp_q;
    steps_left_d = steps_left_q;
    dir_d        = dir_q;
    pos_d        = pos_q;
    step_pulse_d = 1'b0;
    done_d       = 1'b0;
    rem          = steps_left_q - STEPS_W'(1);
    div_x        = {1'b0, div_q};
    div_up       = div_x + DEC_X;
    run          = (state_q == S_ACCEL) || (state_q == S_CRUISE) || (state_q == S_DECEL);

    if (state_q == S_IDLE) begin
      // cmd_ready_q gates acceptance so nothing is taken on the first edge out of reset
      if (cmd.cmd_valid && cmd_ready_q) begin
        if (cmd.cmd_steps == '0) begin
          done_d = 1'b1;
        end else begin
          steps_left_d = cmd.cmd_steps;
          dir_d        = cmd.cmd_dir;
          div_d        = START_V;
          cnt_d        = '0;
          ramp_d       = '0;
          state_d      = S_ACCEL;
        end
      end
    end else if (state_q == S_DONE) begin
      done_d  = 1'b1;
      state_d = S_IDLE;
    end else if (run) begin
      if (cmd.abort) begin
        // abort beats a coincident step boundary: no pulse, position untouched
        state_d      = S_IDLE;
        steps_left_d = '0;
        cnt_d        = '0;
        done_d       = 1'b1;
      end else if (cnt_q == div_q - DIV_W'(1)) begin
        cnt_d        = '0;
        step_pulse_d = 1'b1;
        steps_left_d = rem;
        pos_d        = pos_q + (dir_q ? POS_W'(1) : {POS_W{1'b1}});
        if (rem == '0) begin
          state_d = S_DONE;
        end else if (rem <= ramp_q) begin
          state_d = S_DECEL;
          div_d   = (div_up >= START_X) ? START_V : div_up[DIV_W-1:0];
          ramp_d  = (ramp_q == '0) ? '0 : ramp_q - STEPS_W'(1);
        end else if (state_q == S_ACCEL) begin
          // compare without subtracting so a small div cannot wrap
          if (div_x <= MIN_X + DEC_X) begin
            div_d   = MIN_V;
            state_d = S_CRUISE;
          end else begin
            div_d = div_q - DEC_V;
          end
          ramp_d = ramp_q + STEPS_W'(1);
        end
      end else begin
        cnt_d = cnt_q + DIV_W'(1);
      end
    end else begin
      state_d = S_IDLE;
    end

    cmd_ready_d = (state_d == S_IDLE);
    busy_d      = (state_d == S_ACCEL) || (state_d == S_CRUISE) || (state_d == S_DECEL);
  end

  assign cmd.cmd_ready = cmd_ready_q;
  assign step_pulse    = step_pulse_q;
  assign dir           = dir_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign steps_left    = steps_left_q;
  assign position      = pos_q;

endmodule

// File: tb/tb_stepper_move_ctrl.sv
// Directed bench for stepper_move_ctrl: table of moves with hand-computed step
// gaps, plus abort, busy-reject, reset and position-wrap sequences.
module tb_stepper_move_ctrl;
  localparam int SW = 16;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  always #5 CLK = ~CLK;

  stepper_move_ctrl_if #(.STEPS_W(SW)) cif ();
  stepper_move_ctrl_if #(.STEPS_W(SW)) cif2 ();

  logic                 step_pulse, dir, busy, done;
  logic [SW-1:0]        steps_left;
  logic signed [31:0]   position;
  logic                 step_pulse2, dir2, busy2, done2;
  logic [SW-1:0]        steps_left2;
  logic signed [3:0]    position2;

  stepper_move_ctrl #(.START_DIV(10), .MIN_DIV(4), .ACCEL_DEC(2), .DIV_W(20), .STEPS_W(SW), .POS_W(32)) dut (
    .CLK(CLK), .RST(RST), .cmd(cif),
    .step_pulse(step_pulse), .dir(dir), .busy(busy), .done(done),
    .steps_left(steps_left), .position(position)
  );

  stepper_move_ctrl #(.START_DIV(10), .MIN_DIV(4), .ACCEL_DEC(2), .DIV_W(20), .STEPS_W(SW), .POS_W(4)) dut2 (
    .CLK(CLK), .RST(RST), .cmd(cif2),
    .step_pulse(step_pulse2), .dir(dir2), .busy(busy2), .done(done2),
    .steps_left(steps_left2), .position(position2)
  );

  typedef struct {
    int               steps;
    bit               d;
    int               npulse;
    int               pos;
    int               done_k;
    logic [0:7][7:0]  gap;
  } vec_t;

  vec_t vecs[5];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic add_vec(input int i, input int steps, input bit d, input int np,
                         input int pos, input int dk, input logic [0:7][7:0] g);
    vecs[i].steps = steps; vecs[i].d = d; vecs[i].npulse = np;
    vecs[i].pos = pos; vecs[i].done_k = dk; vecs[i].gap = g;
  endtask

  // Called just after a negedge; returns just after the accept edge.
  task automatic start_move(input int steps, input bit d);
    chk("ready_before_accept", longint'(cif.cmd_ready), 1);
    cif.cmd_valid = 1'b1;
    cif.cmd_steps = SW'(steps);
    cif.cmd_dir   = d;
    @(posedge CLK);
    #1 cif.cmd_valid = 1'b0;
  endtask

  // Six-step forward move aborted at negedge abort_k (sampled on the next edge).
  task automatic run_abort(input string tag, input int abort_k, input int exp_np,
                           input int exp_dk, input int exp_pos);
    int np, dk, late;
    np = 0; dk = -1; late = 0;
    start_move(6, 1'b1);
    for (int k = 0; k < 200 && dk < 0; k++) begin
      @(negedge CLK);
      if (step_pulse) np++;
      if (done) begin
        dk = k;
        cif.abort = 1'b0;
        chk({tag, "_steps_left"}, longint'(steps_left), 0);
        chk({tag, "_busy"}, longint'(busy), 0);
        chk({tag, "_pos"}, longint'(position), exp_pos);
      end else if (k == abort_k) begin
        cif.abort = 1'b1;
      end
    end
    cif.abort = 1'b0;
    for (int k = 0; k < 15; k++) begin
      @(negedge CLK);
      if (step_pulse || busy) late++;
    end
    chk({tag, "_pulses"}, longint'(np), exp_np);
    chk({tag, "_done_k"}, longint'(dk), exp_dk);
    chk({tag, "_quiet_after"}, longint'(late), 0);
  endtask

  task automatic move2(input int steps, input int exp_pos);
    int dk;
    dk = -1;
    cif2.cmd_valid = 1'b1;
    cif2.cmd_steps = SW'(steps);
    cif2.cmd_dir   = 1'b1;
    @(posedge CLK);
    #1 cif2.cmd_valid = 1'b0;
    for (int k = 0; k < 300 && dk < 0; k++) begin
      @(negedge CLK);
      if (done2) dk = k;
    end
    chk("wrap_done_seen", longint'(dk >= 0), 1);
    chk("wrap_pos", longint'(position2), exp_pos);
  endtask

  initial begin
    int np, dk, last, bseen, rej;
    cif.cmd_valid = 0; cif.cmd_steps = '0; cif.cmd_dir = 0; cif.abort = 0;
    cif2.cmd_valid = 0; cif2.cmd_steps = '0; cif2.cmd_dir = 0; cif2.abort = 0;

    add_vec(0, 6, 1'b1, 6,  6, 43, {8'd10, 8'd8, 8'd6, 8'd4, 8'd6, 8'd8, 8'd0, 8'd0});
    add_vec(1, 2, 1'b0, 2,  4, 19, {8'd10, 8'd8, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0});
    add_vec(2, 0, 1'b1, 0,  4,  0, {8'd0,  8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0});
    add_vec(3, 1, 1'b1, 1,  5, 11, {8'd10, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0});
    add_vec(4, 8, 1'b1, 8, 13, 57, {8'd10, 8'd8, 8'd6, 8'd4, 8'd4, 8'd6, 8'd8, 8'd10});

    // reset state
    #2 RST = 1'b1;
    @(negedge CLK); @(negedge CLK);
    chk("rst_ready", longint'(cif.cmd_ready), 0);
    chk("rst_busy", longint'(busy), 0);
    chk("rst_done", longint'(done), 0);
    chk("rst_pulse", longint'(step_pulse), 0);
    chk("rst_dir", longint'(dir), 0);
    chk("rst_steps_left", longint'(steps_left), 0);
    chk("rst_pos", longint'(position), 0);
    RST = 1'b0;
    #1 chk("ready_low_before_edge", longint'(cif.cmd_ready), 0);
    @(negedge CLK);
    chk("ready_after_rst", longint'(cif.cmd_ready), 1);
    chk("ready2_after_rst", longint'(cif2.cmd_ready), 1);

    // table of moves
    for (int i = 0; i < 5; i++) begin
      np = 0; dk = -1; last = 0; bseen = 0;
      start_move(vecs[i].steps, vecs[i].d);
      for (int k = 0; k < 400 && dk < 0; k++) begin
        @(negedge CLK);
        if (busy) bseen = 1;
        if (step_pulse) begin
          if (np < 8) chk($sformatf("v%0d_gap%0d", i, np), longint'(k - last), longint'(vecs[i].gap[np]));
          np++;
          last = k;
          chk($sformatf("v%0d_steps_left", i), longint'(steps_left), longint'(vecs[i].steps - np));
          chk($sformatf("v%0d_dir", i), longint'(dir), longint'(vecs[i].d));
        end
        if (done) begin
          dk = k;
          chk($sformatf("v%0d_busy_at_done", i), longint'(busy), 0);
          chk($sformatf("v%0d_ready_at_done", i), longint'(cif.cmd_ready), 1);
        end
      end
      chk($sformatf("v%0d_pulses", i), longint'(np), longint'(vecs[i].npulse));
      chk($sformatf("v%0d_done_k", i), longint'(dk), longint'(vecs[i].done_k));
      chk($sformatf("v%0d_pos", i), longint'(position), longint'(vecs[i].pos));
      chk($sformatf("v%0d_busy_seen", i), longint'(bseen), longint'(vecs[i].steps != 0));
    end

    // abort 2 cycles after the 3rd pulse, then abort exactly on the 2nd step boundary
    run_abort("abort_mid", 26, 3, 27, 16);
    run_abort("abort_edge", 17, 1, 18, 17);

    // busy reject: second command held through a 2-step reverse move
    chk("rej_ready_idle", longint'(cif.cmd_ready), 1);
    cif.cmd_valid = 1'b1; cif.cmd_steps = SW'(2); cif.cmd_dir = 1'b0;
    @(posedge CLK);
    #1 cif.cmd_steps = SW'(1); cif.cmd_dir = 1'b1;
    dk = -1; rej = 0;
    for (int k = 0; k < 200 && dk < 0; k++) begin
      @(negedge CLK);
      if (done) dk = k;
      else if (cif.cmd_ready) rej++;
    end
    chk("rej_ready_while_busy", longint'(rej), 0);
    chk("rej_done_k", longint'(dk), 19);
    chk("rej_pos", longint'(position), 15);
    @(negedge CLK);
    cif.cmd_valid = 1'b0;
    chk("rej_accept_busy", longint'(busy), 1);
    chk("rej_accept_steps", longint'(steps_left), 1);
    chk("rej_accept_dir", longint'(dir), 1);
    dk = -1;
    for (int k = 0; k < 200 && dk < 0; k++) begin
      @(negedge CLK);
      if (done) dk = k;
    end
    chk("rej_second_done_k", longint'(dk), 10);
    chk("rej_second_pos", longint'(position), 16);

    // reset mid-move clears everything
    start_move(6, 1'b0);
    for (int k = 0; k < 15; k++) @(negedge CLK);
    chk("midrst_pos_before", longint'(position), 15);
    RST = 1'b1;
    #1;
    chk("midrst_pos", longint'(position), 0);
    chk("midrst_busy", longint'(busy), 0);
    chk("midrst_steps_left", longint'(steps_left), 0);
    chk("midrst_ready", longint'(cif.cmd_ready), 0);
    @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    chk("midrst_ready_after", longint'(cif.cmd_ready), 1);

    // 4-bit position wraps from +7 to -8
    move2(7, 7);
    move2(1, -8);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
